byte_store_master: RTL and testbench

//   Requester-side controller for a bank of byte-store cells (write_enable/read_enable/data_in in,

---
 rtl/byte_store_master_pkg.sv | 17 +
 rtl/byte_store_master_slot_decoder.sv | 22 ++
 rtl/byte_store_master.sv | 136 +++++++++++++
 tb/tb_byte_store_master.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_store_master_pkg.sv
// rtl/byte_store_master_pkg.sv - shared types and limits for the byte-store requester
package byte_store_master_pkg;

  localparam int BYTE_W         = 8;
  localparam int MAX_SLOTS      = 16;
  localparam int MAX_RD_LATENCY = 7;
  localparam int LAT_W          = 3;

  typedef enum logic [2:0] {
    IDLE,
    WR_STROBE,
    RD_STROBE,
    RD_WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/byte_store_master_slot_decoder.sv
// rtl/byte_store_master_slot_decoder.sv - slot index to one-hot select with range flag
module byte_store_master_slot_decoder #(
  parameter int NUM_SLOTS = 4,
  parameter int ADDR_W    = 2
) (
  input  logic [ADDR_W-1:0]    addr,
  output logic [NUM_SLOTS-1:0] onehot,
  output logic                 in_range
);

  always_comb begin
    onehot   = '0;
    in_range = 1'b0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (addr == ADDR_W'(k)) begin
        onehot[k] = 1'b1;
        in_range  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/byte_store_master.sv
// rtl/byte_store_master.sv - one-outstanding-request controller driving a bank of byte-store cells
module byte_store_master
  import byte_store_master_pkg::*;
#(
  parameter int NUM_SLOTS  = 4,
  parameter int ADDR_W     = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [BYTE_W-1:0]           req_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [BYTE_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic [NUM_SLOTS-1:0]        st_write_enable,
  output logic [NUM_SLOTS-1:0]        st_read_enable,
  output logic [BYTE_W-1:0]           st_data_in,
  input  logic [BYTE_W*NUM_SLOTS-1:0] st_data_out,
  input  logic [NUM_SLOTS-1:0]        st_output_enable
);

  if (NUM_SLOTS < 1 || NUM_SLOTS > MAX_SLOTS || (1 << ADDR_W) < NUM_SLOTS ||
      RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_params
    $error("byte_store_master: parameter out of range");
  end

  state_t                 state;
  logic [NUM_SLOTS-1:0]   dec_onehot;
  logic                   dec_in_range;
  logic [NUM_SLOTS-1:0]   sel_q;
  logic                   oe_flag;
  logic [LAT_W-1:0]       lat_cnt;
  logic [BYTE_W-1:0]      rd_byte;

  byte_store_master_slot_decoder #(
    .NUM_SLOTS (NUM_SLOTS),
    .ADDR_W    (ADDR_W)
  ) u_dec (
    .addr     (req_addr),
    .onehot   (dec_onehot),
    .in_range (dec_in_range)
  );

  // Latched one-hot select doubles as the read-data mux control
  always_comb begin
    rd_byte = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (sel_q[k]) begin
        rd_byte = rd_byte | st_data_out[BYTE_W*k +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      req_ready       <= 1'b1;
      rsp_valid       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_err         <= 1'b0;
      st_write_enable <= '0;
      st_read_enable  <= '0;
      st_data_in      <= '0;
      sel_q           <= '0;
      oe_flag         <= 1'b0;
      lat_cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            sel_q     <= dec_onehot;
            oe_flag   <= 1'b0;
            if (!dec_in_range) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= RESP;
            end else if (req_write) begin
              st_write_enable <= dec_onehot;
              st_data_in      <= req_wdata;
              state           <= WR_STROBE;
            end else begin
              st_read_enable <= dec_onehot;
              state          <= RD_STROBE;
            end
          end
        end
        WR_STROBE: begin
          st_write_enable <= '0;
          rsp_valid       <= 1'b1;
          rsp_err         <= 1'b0;
          rsp_rdata       <= '0;
          state           <= RESP;
        end
        RD_STROBE: begin
          st_read_enable <= '0;
          oe_flag        <= |(st_output_enable & sel_q);
          lat_cnt        <= LAT_W'(RD_LATENCY);
          state          <= RD_WAIT;
        end
        RD_WAIT: begin
          // Capture on the cycle the counter reaches zero; it never wraps
          if (lat_cnt <= LAT_W'(1)) begin
            lat_cnt   <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= ~oe_flag;
            rsp_rdata <= oe_flag ? rd_byte : '0;
            state     <= RESP;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_store_master.sv
// tb/tb_byte_store_master.sv - self-checking bench with cell models and response scoreboard
module tb_byte_store_master;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } rsp_t;

  typedef struct {
    bit         d3;
    logic       wr;
    logic [1:0] addr;
    logic [7:0] wd;
    logic [3:0] strobe;
    logic [7:0] rdata;
    logic       err;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_write;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_ready;
  bit         sel3;
  logic       oe_en4;

  logic       rr4, rv4, err4;
  logic [7:0] rdata4, din4;
  logic [3:0] we4, re4, oe4;
  logic [31:0] dout4;

  logic       rr3, rv3, err3;
  logic [7:0] rdata3, din3;
  logic [2:0] we3, re3, oe3;
  logic [23:0] dout3;

  int checks;
  int errors;
  rsp_t q4[$];
  rsp_t q3[$];

  byte_store_master #(.NUM_SLOTS(4), .ADDR_W(2), .RD_LATENCY(1)) dut4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && !sel3), .req_ready(rr4), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv4), .rsp_ready(rsp_ready), .rsp_rdata(rdata4), .rsp_err(err4),
    .st_write_enable(we4), .st_read_enable(re4), .st_data_in(din4),
    .st_data_out(dout4), .st_output_enable(oe4)
  );

  byte_store_master #(.NUM_SLOTS(3), .ADDR_W(2), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && sel3), .req_ready(rr3), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv3), .rsp_ready(rsp_ready), .rsp_rdata(rdata3), .rsp_err(err3),
    .st_write_enable(we3), .st_read_enable(re3), .st_data_in(din3),
    .st_data_out(dout3), .st_output_enable(oe3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cell models: writes land on the strobe edge, read data appears exactly L cycles after the strobe
  logic [7:0]  mem4 [4];
  logic [31:0] pipe4;
  logic [7:0]  mem3 [3];
  logic [23:0] pipe3 [3];

  assign oe4   = re4 & {4{oe_en4}};
  assign dout4 = pipe4;
  assign oe3   = re3;
  assign dout3 = pipe3[2];

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (we4[k]) mem4[k] <= din4;
      pipe4[8*k +: 8] <= re4[k] ? mem4[k] : 8'h00;
    end
    for (int k = 0; k < 3; k++) begin
      if (we3[k]) mem3[k] <= din3;
      pipe3[0][8*k +: 8] <= re3[k] ? mem3[k] : 8'h00;
    end
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  logic       cur_rr, cur_rv;
  logic [3:0] cur_we, cur_re;
  logic [7:0] cur_din;
  assign cur_rr  = sel3 ? rr3 : rr4;
  assign cur_rv  = sel3 ? rv3 : rv4;
  assign cur_we  = sel3 ? {1'b0, we3} : we4;
  assign cur_re  = sel3 ? {1'b0, re3} : re4;
  assign cur_din = sel3 ? din3 : din4;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    rsp_t e;
    if (rv4 && rsp_ready) begin
      chk("rsp4_pending", 32'(q4.size() != 0), 32'd1);
      if (q4.size() != 0) begin
        e = q4.pop_front();
        chk("rsp4_rdata", 32'(rdata4), 32'(e.rdata));
        chk("rsp4_err", 32'(err4), 32'(e.err));
      end
    end
    if (rv3 && rsp_ready) begin
      chk("rsp3_pending", 32'(q3.size() != 0), 32'd1);
      if (q3.size() != 0) begin
        e = q3.pop_front();
        chk("rsp3_rdata", 32'(rdata3), 32'(e.rdata));
        chk("rsp3_err", 32'(err3), 32'(e.err));
      end
    end
  end

  task automatic run_txn(input bit d3, input logic wr, input logic [1:0] addr,
                         input logic [7:0] wd, input logic [3:0] strobe,
                         input logic [7:0] exp_rdata, input logic exp_err, input int hold);
    int n, k, exp_lat, we_hits, re_hits;
    logic [3:0] we_val, re_val;
    logic [7:0] din_val;
    logic seen;
    rsp_t e;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    if (d3) q3.push_back(e); else q4.push_back(e);
    exp_lat = (strobe == 4'b0) ? 1 : (wr ? 2 : 2 + (d3 ? 3 : 1));
    sel3 = d3;
    req_write = wr; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    rsp_ready = (hold == 0);
    n = 0;
    while (!cur_rr && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept", 32'(cur_rr), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    we_hits = 0; re_hits = 0; we_val = '0; re_val = '0; din_val = '0;
    seen = 1'b0; k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (cur_we != 4'b0) begin we_hits++; we_val = cur_we; din_val = cur_din; end
      if (cur_re != 4'b0) begin re_hits++; re_val = cur_re; end
      if (cur_rv) seen = 1'b1;
    end
    chk("rsp_latency", 32'(k), 32'(exp_lat));
    chk("we_hits", 32'(we_hits), 32'((wr && strobe != 4'b0) ? 1 : 0));
    chk("re_hits", 32'(re_hits), 32'((!wr && strobe != 4'b0) ? 1 : 0));
    if (wr) chk("we_value", 32'(we_val), 32'(strobe));
    else    chk("re_value", 32'(re_val), 32'(strobe));
    if (wr && strobe != 4'b0) chk("data_in", 32'(din_val), 32'(wd));
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("hold_valid", 32'(cur_rv), 32'd1);
        chk("hold_rdata", 32'(d3 ? rdata3 : rdata4), 32'(exp_rdata));
        chk("hold_err", 32'(d3 ? err3 : err4), 32'(exp_err));
        chk("hold_req_ready", 32'(cur_rr), 32'd0);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    chk("back_to_idle_ready", 32'(cur_rr), 32'd1);
    chk("back_to_idle_valid", 32'(cur_rv), 32'd0);
  endtask

  vec_t tbl [14];

  initial begin
    int rises;
    tbl[0]  = '{0, 1, 2'd0, 8'h11, 4'b0001, 8'h00, 0};
    tbl[1]  = '{0, 1, 2'd1, 8'h22, 4'b0010, 8'h00, 0};
    tbl[2]  = '{0, 1, 2'd2, 8'hA5, 4'b0100, 8'h00, 0};
    tbl[3]  = '{0, 1, 2'd3, 8'h44, 4'b1000, 8'h00, 0};
    tbl[4]  = '{0, 0, 2'd2, 8'h00, 4'b0100, 8'hA5, 0};
    tbl[5]  = '{0, 0, 2'd0, 8'h00, 4'b0001, 8'h11, 0};
    tbl[6]  = '{0, 0, 2'd3, 8'h00, 4'b1000, 8'h44, 0};
    tbl[7]  = '{0, 1, 2'd3, 8'hFF, 4'b1000, 8'h00, 0};
    tbl[8]  = '{0, 0, 2'd3, 8'h00, 4'b1000, 8'hFF, 0};
    tbl[9]  = '{0, 0, 2'd1, 8'h00, 4'b0010, 8'h22, 0};
    tbl[10] = '{1, 1, 2'd1, 8'h5A, 4'b0010, 8'h00, 0};
    tbl[11] = '{1, 0, 2'd1, 8'h00, 4'b0010, 8'h5A, 0};
    tbl[12] = '{1, 0, 2'd3, 8'h00, 4'b0000, 8'h00, 1};
    tbl[13] = '{1, 1, 2'd3, 8'h77, 4'b0000, 8'h00, 1};

    checks = 0; errors = 0;
    sel3 = 0; oe_en4 = 1'b1; rsp_ready = 1'b1;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(rr4), 32'd1);
    chk("reset_rsp_valid", 32'(rv4), 32'd0);
    chk("reset_rsp_rdata", 32'(rdata4), 32'd0);
    chk("reset_rsp_err", 32'(err4), 32'd0);
    chk("reset_st_outputs", {12'd0, we4, re4, din4}, 32'd0);
    chk("reset3_outputs", {16'd0, rr3, rv3, we3, re3, din3}, 32'h0000_8000 >> 0 & 32'h0 | {16'd0, 1'b1, 15'd0});

    for (int i = 0; i < 14; i++) begin
      run_txn(tbl[i].d3, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].strobe,
              tbl[i].rdata, tbl[i].err, 0);
    end
    chk("data_in_kept", 32'(din4), 32'hFF);

    oe_en4 = 1'b0;
    run_txn(0, 0, 2'd0, 8'h00, 4'b0001, 8'h00, 1'b1, 5);
    oe_en4 = 1'b1;

    sel3 = 0; req_write = 1; req_addr = 2'd1; req_wdata = 8'h3C; req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    chk("abort_we_before", 32'(we4), 32'h2);
    #2 rst = 1'b1;
    #1;
    chk("abort_we_async", 32'(we4), 32'd0);
    chk("abort_din_async", 32'(din4), 32'd0);
    chk("abort_ready_async", 32'(rr4), 32'd1);
    chk("abort_valid_async", 32'(rv4), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_txn(0, 0, 2'd1, 8'h00, 4'b0010, 8'h22, 1'b0, 0);

    req_write = 0; req_addr = 2'd2; req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    chk("rdwait_strobe", 32'(re4), 32'h4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rdwait_rst_valid", 32'(rv4), 32'd0);
    chk("rdwait_rst_re", 32'(re4), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rises = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rv4) rises++;
    end
    chk("rdwait_no_response", 32'(rises), 32'd0);
    run_txn(0, 0, 2'd2, 8'h00, 4'b0100, 8'hA5, 1'b0, 0);

    chk("q4_drained", 32'(q4.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
